// File: rtl/memory_access_pkg.sv
// memory_access_pkg: shared widths, opcodes, funct3 codes, FSM states and lane helpers for the MEM stage
package memory_access_pkg;
  localparam int XLEN  = 32;
  localparam int XADDR = 5;
  localparam int OPLEN = 7;
  localparam logic [OPLEN-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OPLEN-1:0] OP_STORE = 7'b0100011;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  // Byte offset actually used: halfwords honour a[1] only, words ignore a[1:0]
  function automatic logic [1:0] lane_off(input logic [2:0] f3, input logic [1:0] a);
    return f3[1] ? 2'b00 : f3[0] ? {a[1], 1'b0} : a;
  endfunction
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
    return f3[1] ? 4'hF : ((f3[0] ? 4'b0011 : 4'b0001) << lane_off(f3, a));
  endfunction
  function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] f3, input logic [XLEN-1:0] d);
    return f3[1] ? d : f3[0] ? {2{d[15:0]}} : {4{d[7:0]}};
  endfunction
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return f3[1] ? (a != 2'b00) : (f3[0] & a[0]);
  endfunction
endpackage

// File: rtl/memory_access_if.sv
// memory_access_if: valid/ready data-memory bus between the MEM stage (master) and data memory (slave)
interface memory_access_if;
  logic                               req;
  logic                               we;
  logic [memory_access_pkg::XLEN-1:0] addr;
  logic [memory_access_pkg::XLEN-1:0] wdata;
  logic [3:0]                         wstrb;
  logic                               ready;
  logic                               rvalid;
  logic [memory_access_pkg::XLEN-1:0] rdata;
  modport master (output req, we, addr, wdata, wstrb, input ready, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, wstrb, output ready, rvalid, rdata);
endinterface

// File: rtl/memory_access_load_align.sv
// memory_access_load_align: shifts the loaded word to the addressed lane and sign/zero extends it
module memory_access_load_align
  import memory_access_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);
  logic [XLEN-1:0] sh;
  assign sh = rdata >> {lane_off(funct3, off), 3'b000};
  always_comb data = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                     funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                     funct3 == F3_BU ? {24'b0, sh[7:0]} :
                     funct3 == F3_HU ? {16'b0, sh[15:0]} : sh;
endmodule

// File: rtl/memory_access.sv
// memory_access: RV32I MEM stage running loads/stores over a valid/ready bus, passing other ops through.
// Optional MEM_MISALIGN_TRAP_EN reports misaligned accesses instead of issuing them.
module memory_access
  import memory_access_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic [OPLEN-1:0]   i_opcode,
  input  logic [2:0]         i_funct3,
  input  logic [XLEN-1:0]    i_alu_result,
  input  logic [XLEN-1:0]    i_rs2_data,
  input  logic [XADDR-1:0]   i_rd_addr,
  input  logic               i_rd_write,
  input  logic [XLEN-1:0]    i_pc,
  memory_access_if.master    dmem,
  output logic               or_valid,
  output logic [XADDR-1:0]   or_rd_addr,
  output logic               or_rd_write,
  output logic [XLEN-1:0]    or_rd_data,
  output logic [XLEN-1:0]    or_pc,
  output logic [OPLEN-1:0]   or_opcode,
  output logic [2:0]         or_funct3,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic               or_misalign,
  output logic [XLEN-1:0]    or_misalign_addr,
`endif
  output logic               o_stall
);
  state_t          state;
  logic [1:0]      a_q;
  logic [XLEN-1:0] ld_data;
  logic            is_st, is_ls, mis;
  assign is_st   = i_opcode == OP_STORE;
  assign is_ls   = is_st || i_opcode == OP_LOAD;
  assign o_stall = state != IDLE;
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = is_ls && misaligned(i_funct3, i_alu_result[1:0]);
`else
  assign mis = 1'b0;
`endif
  memory_access_load_align u_align (.rdata(dmem.rdata), .off(a_q), .funct3(or_funct3), .data(ld_data));
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      or_valid    <= 1'b0;
      or_rd_addr  <= '0;
      or_rd_write <= 1'b0;
      or_rd_data  <= '0;
      or_pc       <= '0;
      or_opcode   <= '0;
      or_funct3   <= '0;
      dmem.req    <= 1'b0;
      dmem.we     <= 1'b0;
      dmem.addr   <= '0;
      dmem.wdata  <= '0;
      dmem.wstrb  <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      or_misalign      <= 1'b0;
      or_misalign_addr <= '0;
`endif
    end else begin
      or_valid <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      or_misalign <= 1'b0;
`endif
      case (state)
        IDLE: if (i_valid) begin
          or_rd_addr  <= i_rd_addr;
          or_rd_write <= i_rd_write && i_rd_addr != '0 && !is_st && !mis;
          or_rd_data  <= i_alu_result;
          or_pc       <= i_pc;
          or_opcode   <= i_opcode;
          or_funct3   <= i_funct3;
          a_q         <= i_alu_result[1:0];
          if (mis) begin
            or_valid <= 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
            or_misalign      <= 1'b1;
            or_misalign_addr <= i_alu_result;
`endif
          end else if (is_ls) begin
            state      <= REQ;
            dmem.req   <= 1'b1;
            dmem.we    <= is_st;
            dmem.addr  <= {i_alu_result[XLEN-1:2], 2'b00};
            dmem.wdata <= store_wdata(i_funct3, i_rs2_data);
            dmem.wstrb <= is_st ? store_strb(i_funct3, i_alu_result[1:0]) : 4'h0;
          end else begin
            or_valid <= 1'b1;
          end
        end
        REQ: if (dmem.ready) begin
          dmem.req <= 1'b0;
          state    <= dmem.we ? IDLE : RESP;
          or_valid <= dmem.we;
        end
        RESP: if (dmem.rvalid) begin
          or_rd_data <= ld_data;
          or_valid   <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed self-checking bench for the MEM stage (define MEM_MISALIGN_TRAP_EN to cover the trap build)
module tb_memory_access;
  import memory_access_pkg::*;
  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_valid = 1'b0;
  logic [OPLEN-1:0]  i_opcode = '0;
  logic [2:0]        i_funct3 = '0;
  logic [XLEN-1:0]   i_alu_result = '0;
  logic [XLEN-1:0]   i_rs2_data = '0;
  logic [XADDR-1:0]  i_rd_addr = '0;
  logic              i_rd_write = 1'b0;
  logic [XLEN-1:0]   i_pc = '0;
  logic              or_valid, or_rd_write, o_stall;
  logic [XADDR-1:0]  or_rd_addr;
  logic [XLEN-1:0]   or_rd_data, or_pc;
  logic [OPLEN-1:0]  or_opcode;
  logic [2:0]        or_funct3;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              or_misalign;
  logic [XLEN-1:0]   or_misalign_addr;
`endif
  int n_chk = 0;
  int n_fail = 0;
  localparam logic [OPLEN-1:0] OP_ADD = 7'b0110011;

  memory_access_if dmem ();

  memory_access dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_opcode(i_opcode),
    .i_funct3(i_funct3), .i_alu_result(i_alu_result), .i_rs2_data(i_rs2_data),
    .i_rd_addr(i_rd_addr), .i_rd_write(i_rd_write), .i_pc(i_pc), .dmem(dmem),
    .or_valid(or_valid), .or_rd_addr(or_rd_addr), .or_rd_write(or_rd_write),
    .or_rd_data(or_rd_data), .or_pc(or_pc), .or_opcode(or_opcode), .or_funct3(or_funct3),
`ifdef MEM_MISALIGN_TRAP_EN
    .or_misalign(or_misalign), .or_misalign_addr(or_misalign_addr),
`endif
    .o_stall(o_stall)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [OPLEN-1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] rs2, input logic [4:0] rd, input logic rdw);
    i_valid = 1'b1; i_opcode = op; i_funct3 = f3; i_alu_result = addr;
    i_rs2_data = rs2; i_rd_addr = rd; i_rd_write = rdw; i_pc = addr + 32'h1000;
    tick();
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                         input logic [31:0] rdata);
    issue(OP_LOAD, f3, addr, 32'h0, rd, 1'b1);
    dmem.ready = 1'b1; tick(); dmem.ready = 1'b0;
    dmem.rvalid = 1'b1; dmem.rdata = rdata; tick(); dmem.rvalid = 1'b0;
    i_valid = 1'b0;
  endtask

  initial begin
    dmem.ready = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
    tick(); tick();
    chk("rst_valid", 32'(or_valid), 32'd0);
    chk("rst_rd_data", or_rd_data, 32'h0);
    chk("rst_req", 32'(dmem.req), 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    i_rst_n = 1'b1;
    // pass-through ALU op
    issue(OP_ADD, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1);
    chk("add_valid", 32'(or_valid), 32'd1);
    chk("add_rd_data", or_rd_data, 32'h1234);
    chk("add_rd_write", 32'(or_rd_write), 32'd1);
    chk("add_rd_addr", 32'(or_rd_addr), 32'd5);
    chk("add_pc", or_pc, 32'h2234);
    chk("add_stall", 32'(o_stall), 32'd0);
    i_valid = 1'b0; tick();
    chk("idle_valid", 32'(or_valid), 32'd0);
    chk("idle_hold", or_rd_data, 32'h1234);
    // SB to byte 3, ready in first REQ cycle
    issue(OP_STORE, F3_B, 32'h103, 32'hAB, 5'd0, 1'b0);
    chk("sb_req", 32'(dmem.req), 32'd1);
    chk("sb_we", 32'(dmem.we), 32'd1);
    chk("sb_addr", dmem.addr, 32'h100);
    chk("sb_wstrb", 32'(dmem.wstrb), 32'h8);
    chk("sb_wdata", dmem.wdata, 32'hABABABAB);
    chk("sb_stall", 32'(o_stall), 32'd1);
    chk("sb_nvalid", 32'(or_valid), 32'd0);
    dmem.ready = 1'b1; tick(); dmem.ready = 1'b0; i_valid = 1'b0;
    chk("sb_done_valid", 32'(or_valid), 32'd1);
    chk("sb_done_rdw", 32'(or_rd_write), 32'd0);
    chk("sb_done_req", 32'(dmem.req), 32'd0);
    chk("sb_done_stall", 32'(o_stall), 32'd0);
    tick();
    chk("sb_bubble", 32'(or_valid), 32'd0);
    // SH and SW lanes
    issue(OP_STORE, F3_H, 32'h102, 32'h1234ABCD, 5'd0, 1'b0);
    chk("sh_wstrb", 32'(dmem.wstrb), 32'hC);
    chk("sh_wdata", dmem.wdata, 32'hABCDABCD);
    dmem.ready = 1'b1; tick(); dmem.ready = 1'b0; i_valid = 1'b0; tick();
    issue(OP_STORE, F3_W, 32'h200, 32'hCAFEF00D, 5'd0, 1'b0);
    chk("sw_wstrb", 32'(dmem.wstrb), 32'hF);
    chk("sw_wdata", dmem.wdata, 32'hCAFEF00D);
    dmem.ready = 1'b1; tick(); dmem.ready = 1'b0; i_valid = 1'b0; tick();
    // LB with slow ready and late rvalid
    issue(OP_LOAD, F3_B, 32'h102, 32'h0, 5'd7, 1'b1);
    chk("lb_req", 32'(dmem.req), 32'd1);
    chk("lb_we", 32'(dmem.we), 32'd0);
    chk("lb_wstrb", 32'(dmem.wstrb), 32'h0);
    chk("lb_addr", dmem.addr, 32'h100);
    tick();
    chk("lb_wait_req", 32'(dmem.req), 32'd1);
    chk("lb_wait_stall", 32'(o_stall), 32'd1);
    dmem.ready = 1'b1; tick(); dmem.ready = 1'b0;
    chk("lb_resp_req", 32'(dmem.req), 32'd0);
    chk("lb_resp_stall", 32'(o_stall), 32'd1);
    tick();
    chk("lb_resp2_stall", 32'(o_stall), 32'd1);
    chk("lb_resp2_valid", 32'(or_valid), 32'd0);
    dmem.rvalid = 1'b1; dmem.rdata = 32'h0080FF00; tick(); dmem.rvalid = 1'b0; i_valid = 1'b0;
    chk("lb_valid", 32'(or_valid), 32'd1);
    chk("lb_data", or_rd_data, 32'hFFFFFF80);
    chk("lb_rdw", 32'(or_rd_write), 32'd1);
    chk("lb_rd", 32'(or_rd_addr), 32'd7);
    tick();
    // other load widths
    do_load(F3_HU, 32'h202, 5'd9, 32'hBEEF1234);
    chk("lhu_data", or_rd_data, 32'h0000BEEF);
    chk("lhu_valid", 32'(or_valid), 32'd1);
    tick();
    do_load(F3_H, 32'h202, 5'd9, 32'h80010000);
    chk("lh_data", or_rd_data, 32'hFFFF8001);
    tick();
    do_load(F3_BU, 32'h101, 5'd9, 32'h0000C300);
    chk("lbu_data", or_rd_data, 32'h000000C3);
    tick();
    do_load(F3_W, 32'h300, 5'd0, 32'hDEADBEEF);
    chk("lw_x0_data", or_rd_data, 32'hDEADBEEF);
    chk("lw_x0_rdw", 32'(or_rd_write), 32'd0);
    tick();
`ifdef MEM_MISALIGN_TRAP_EN
    issue(OP_LOAD, F3_W, 32'h101, 32'h0, 5'd3, 1'b1);
    i_valid = 1'b0;
    chk("mis_req", 32'(dmem.req), 32'd0);
    chk("mis_stall", 32'(o_stall), 32'd0);
    chk("mis_valid", 32'(or_valid), 32'd1);
    chk("mis_flag", 32'(or_misalign), 32'd1);
    chk("mis_addr", or_misalign_addr, 32'h101);
    chk("mis_rdw", 32'(or_rd_write), 32'd0);
    tick();
    chk("mis_clear", 32'(or_misalign), 32'd0);
    chk("mis_idle_req", 32'(dmem.req), 32'd0);
`else
    issue(OP_LOAD, F3_W, 32'h101, 32'h0, 5'd3, 1'b1);
    chk("lw_mis_req", 32'(dmem.req), 32'd1);
    chk("lw_mis_addr", dmem.addr, 32'h100);
    dmem.ready = 1'b1; tick(); dmem.ready = 1'b0;
    dmem.rvalid = 1'b1; dmem.rdata = 32'h11223344; tick(); dmem.rvalid = 1'b0; i_valid = 1'b0;
    chk("lw_mis_data", or_rd_data, 32'h11223344);
    tick();
    do_load(F3_H, 32'h203, 5'd3, 32'hF00D0000);
    chk("lh_odd_data", or_rd_data, 32'hFFFFF00D);
    tick();
`endif
    // reset while waiting in RESP, then a stray rvalid
    issue(OP_LOAD, F3_W, 32'h400, 32'h0, 5'd4, 1'b1);
    dmem.ready = 1'b1; tick(); dmem.ready = 1'b0; i_valid = 1'b0;
    chk("rr_in_resp", 32'(o_stall), 32'd1);
    i_rst_n = 1'b0; tick(); i_rst_n = 1'b1;
    chk("rr_stall", 32'(o_stall), 32'd0);
    chk("rr_data", or_rd_data, 32'h0);
    chk("rr_req", 32'(dmem.req), 32'd0);
    dmem.rvalid = 1'b1; dmem.rdata = 32'h55555555; tick(); dmem.rvalid = 1'b0;
    chk("rr_stray_valid", 32'(or_valid), 32'd0);
    chk("rr_stray_data", or_rd_data, 32'h0);
    chk("rr_stray_stall", 32'(o_stall), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
